// File: rtl/arbiter_rr_burst.sv
// Round-robin burst arbiter: one registered one-hot owner at a time, ownership
// ends on beat_last, MAX_BURST beats, or request withdrawal; back-to-back hand-over.
module arbiter_rr_burst #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8,
  parameter int IDW       = $clog2(N),
  parameter int CNTW      = $clog2(MAX_BURST + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            beat,
  input  logic            beat_last,
  output logic [N-1:0]    grant,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic [CNTW-1:0] beat_cnt,
  output logic            burst_trunc
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
  logic            trunc_q, trunc_d;

  logic [IDW-1:0]  arb_ptr, pick;
  logic [N-1:0]    masked;
  logic            pick_vld;
  logic            last_hit, max_hit, drop_hit, rel;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    if (32'(i) == N - 1) return '0;
    return i + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] lowest(input logic [N-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int unsigned i = N; i > 0; i--)
      if (v[i-1]) idx = IDW'(i - 1);
    return idx;
  endfunction

  // While owning, arbitrate as if ptr had already moved past the owner so a
  // release can hand over in the same cycle.
  always_comb begin
    arb_ptr  = (state_q == OWN) ? wrap_inc(grant_id_q) : ptr_q;
    masked   = '0;
    for (int unsigned i = 0; i < N; i++)
      masked[i] = req[i] & (IDW'(i) >= arb_ptr);
    pick_vld = |req;
    pick     = (|masked) ? lowest(masked) : lowest(req);
  end

  always_comb begin
    last_hit = beat & beat_last;
    max_hit  = beat & (beat_cnt_q == CNTW'(MAX_BURST - 1));
    drop_hit = ~req[grant_id_q] & ~beat;
    rel      = last_hit | max_hit | drop_hit;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        grant_d    = '0;
        if (pick_vld) begin
          grant_d[pick] = 1'b1;
          grant_id_d    = pick;
          state_d       = OWN;
        end
      end
      OWN: begin
        if (rel) begin
          ptr_d      = arb_ptr;
          trunc_d    = max_hit & ~beat_last;
          beat_cnt_d = '0;
          grant_d    = '0;
          if (pick_vld) begin
            grant_d[pick] = 1'b1;
            grant_id_d    = pick;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign busy        = |grant_q;
  assign beat_cnt    = beat_cnt_q;
  assign burst_trunc = trunc_q;

endmodule

// File: tb/tb_arbiter_rr_burst.sv
// Directed bench for arbiter_rr_burst (N=4, MAX_BURST=8).
// Observed vector layout: {grant[3:0], busy, beat_cnt[3:0], burst_trunc}.
module tb_arbiter_rr_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       beat = 1'b0;
  logic       beat_last = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] beat_cnt;
  logic       burst_trunc;

  logic [9:0] obs;
  logic [9:0] exp;
  int checks = 0;
  int errors = 0;

  arbiter_rr_burst #(.N(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .beat(beat), .beat_last(beat_last),
    .grant(grant), .grant_id(grant_id), .busy(busy), .beat_cnt(beat_cnt),
    .burst_trunc(burst_trunc)
  );

  always #5 clk = ~clk;
  assign obs = {grant, busy, beat_cnt, burst_trunc};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; beat = 1'b0; beat_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; beat = 1'b1; beat_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp = {4'b0000, 1'b0, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state got %b want %b", obs, exp); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    req = 4'b0101;
    tick();
    exp = {4'b0001, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_first_grant got %b want %b", obs, exp); end
    beat = 1'b0; beat_last = 1'b1;
    tick();
    exp = {4'b0001, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_last_no_beat got %b want %b", obs, exp); end
    beat = 1'b1; beat_last = 1'b0;
    tick(); tick();
    exp = {4'b0001, 1'b1, 4'd2, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_two_beats got %b want %b", obs, exp); end
    beat_last = 1'b1;
    tick();
    exp = {4'b0100, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_handover got %b want %b", obs, exp); end
    checks++;
    if (grant_id !== 2'd2) begin errors++; $display("FAIL basic_grant_id got %0d want 2", grant_id); end
    beat = 1'b0; beat_last = 1'b0;
  endtask

  task automatic test_max_burst();
    logic [3:0] og;
    do_reset();
    req = 4'b1111; beat = 1'b1; beat_last = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      og = 4'b0001 << (k % 4);
      for (int c = 0; c < 8; c++) begin
        exp = {og, 1'b1, 4'(c), (c == 0 && k > 0)}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL max_burst k%0d c%0d got %b want %b", k, c, obs, exp); end
        tick();
      end
    end
    beat = 1'b0;
  endtask

  task automatic test_last_on_max();
    do_reset();
    req = 4'b0011; beat = 1'b1; beat_last = 1'b0;
    tick();
    repeat (7) tick();
    exp = {4'b0001, 1'b1, 4'd7, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL lastmax_cnt7 got %b want %b", obs, exp); end
    beat_last = 1'b1;
    tick();
    exp = {4'b0010, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL lastmax_no_trunc got %b want %b", obs, exp); end
    beat = 1'b0; beat_last = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1011;
    tick();
    exp = {4'b0010, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL drop_owner_held got %b want %b", obs, exp); end
    req = 4'b1001;
    tick();
    exp = {4'b1000, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL drop_handover got %b want %b", obs, exp); end
    checks++;
    if (grant_id !== 2'd3) begin errors++; $display("FAIL drop_grant_id got %0d want 3", grant_id); end
    beat = 1'b1; beat_last = 1'b1;
    tick();
    exp = {4'b0001, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL drop_wrap got %b want %b", obs, exp); end
    beat = 1'b0; beat_last = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0100;
    tick();
    for (int b = 0; b < 2; b++) begin
      beat = 1'b1; beat_last = 1'b0;
      tick();
      exp = {4'b0100, 1'b1, 4'd1, 1'b0}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b_mid b%0d got %b want %b", b, obs, exp); end
      beat_last = 1'b1;
      tick();
      exp = {4'b0100, 1'b1, 4'd0, 1'b0}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b_regrant b%0d got %b want %b", b, obs, exp); end
    end
    beat = 1'b0; beat_last = 1'b0; req = 4'b0000;
    tick();
    exp = {4'b0000, 1'b0, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_idle got %b want %b", obs, exp); end
    beat = 1'b1; beat_last = 1'b1;
    tick();
    exp = {4'b0000, 1'b0, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL idle_beat_ignored got %b want %b", obs, exp); end
    beat = 1'b0; beat_last = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1000;
    tick();
    beat = 1'b1;
    repeat (5) tick();
    exp = {4'b1000, 1'b1, 4'd5, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL arst_pre got %b want %b", obs, exp); end
    #2 rst_n = 1'b0;
    #1;
    exp = {4'b0000, 1'b0, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL arst_immediate got %b want %b", obs, exp); end
    req = 4'b1111; beat = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    exp = {4'b0001, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL arst_ptr0 got %b want %b", obs, exp); end
  endtask

  task automatic test_beat_on_drop();
    do_reset();
    req = 4'b0011;
    tick();
    beat = 1'b1; beat_last = 1'b0;
    repeat (6) tick();
    exp = {4'b0001, 1'b1, 4'd6, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL bdrop_cnt6 got %b want %b", obs, exp); end
    req = 4'b0010;
    tick();
    exp = {4'b0001, 1'b1, 4'd7, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL bdrop_counted got %b want %b", obs, exp); end
    beat = 1'b0;
    tick();
    exp = {4'b0010, 1'b1, 4'd0, 1'b0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL bdrop_release got %b want %b", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_burst();
    test_last_on_max();
    test_drop();
    test_back_to_back();
    test_async_reset();
    test_beat_on_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
